obstacle_ctrl: RTL and testbench

Sequencing FSM for the obstacle-course sprite datapath. It drives every enable and select of that datapath to run a per-frame loop:
- draw the sprite pixel, then wait on the datapath timer;
- erase the pixel;
- probe obstacle memory ahead of the sprite on each axis, bouncing on any hit;
- step the position.

It also emits the VGA adapter `plot` strobe. It sits between top-level start/pause controls and the datapath.

---
 rtl/obstacle_ctrl_pkg.sv | 41 ++++
 rtl/obstacle_ctrl_if.sv | 38 +++
 rtl/obstacle_ctrl.sv | 125 ++++++++++++
 tb/tb_obstacle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_ctrl_pkg.sv
// Shared encodings for the obstacle-course sprite controller and its datapath.
package obstacle_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_DRAW  = 4'd2,
        S_WAIT  = 4'd3,
        S_ERASE = 4'd4,
        S_PRX   = 4'd5,
        S_EVX   = 4'd6,
        S_PRY   = 4'd7,
        S_EVY   = 4'd8,
        S_MOVE  = 4'd9
    } state_t;

    // Position register selects: load start point, step, or clear.
    localparam logic [SEL_W-1:0] POS_LOAD = 2'd0;
    localparam logic [SEL_W-1:0] POS_DEC  = 2'd1;
    localparam logic [SEL_W-1:0] POS_INC  = 2'd2;
    localparam logic [SEL_W-1:0] POS_ZERO = 2'd3;

    // Obstacle probe directions relative to the sprite.
    localparam logic [SEL_W-1:0] PRB_UP    = 2'd0;
    localparam logic [SEL_W-1:0] PRB_DOWN  = 2'd1;
    localparam logic [SEL_W-1:0] PRB_LEFT  = 2'd2;
    localparam logic [SEL_W-1:0] PRB_RIGHT = 2'd3;

    localparam logic DIR_SET    = 1'b0;
    localparam logic DIR_TOGGLE = 1'b1;
    localparam logic TMR_CLEAR  = 1'b0;
    localparam logic TMR_INC    = 1'b1;

    function automatic logic [SEL_W-1:0] step_sel(input logic dir);
        return dir ? POS_INC : POS_DEC;
    endfunction

endpackage

// File: rtl/obstacle_ctrl_if.sv
// Control/status bundle between the sequencing FSM and the sprite datapath.
interface obstacle_ctrl_if;
    import obstacle_ctrl_pkg::*;

    logic             start;
    logic             pause;
    logic             xdir;
    logic             ydir;
    logic             timer_done;
    logic             obstacle;
    logic             en_xpos;
    logic [SEL_W-1:0] s_xpos;
    logic             en_ypos;
    logic [SEL_W-1:0] s_ypos;
    logic             en_xdir;
    logic             s_xdir;
    logic             en_ydir;
    logic             s_ydir;
    logic             en_timer;
    logic             s_timer;
    logic             s_color;
    logic [SEL_W-1:0] s_obs_xy;
    logic             plot;
    logic             busy;

    modport master (
        input  start, pause, xdir, ydir, timer_done, obstacle,
        output en_xpos, s_xpos, en_ypos, s_ypos, en_xdir, s_xdir,
               en_ydir, s_ydir, en_timer, s_timer, s_color, s_obs_xy, plot, busy
    );

    modport slave (
        output start, pause, xdir, ydir, timer_done, obstacle,
        input  en_xpos, s_xpos, en_ypos, s_ypos, en_xdir, s_xdir,
               en_ydir, s_ydir, en_timer, s_timer, s_color, s_obs_xy, plot, busy
    );

endinterface

// File: rtl/obstacle_ctrl.sv
// Per-frame sequencer: draw, wait on timer, erase, probe obstacles per axis, step.
module obstacle_ctrl
    import obstacle_ctrl_pkg::*;
#(
    parameter int unsigned OBS_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    obstacle_ctrl_if.master bus
);

    // The EV states sample the probe result exactly one cycle after PR.
    if (OBS_LAT != 1) begin : g_bad_obs_lat
        $error("obstacle_ctrl: only OBS_LAT == 1 is supported");
    end

    state_t state;
    logic   blk_x;
    logic   blk_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            blk_x <= 1'b0;
            blk_y <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state <= S_INIT;
                S_INIT:  state <= S_DRAW;
                S_DRAW:  state <= S_WAIT;
                S_WAIT:  if (bus.timer_done) state <= S_ERASE;
                S_ERASE: state <= S_PRX;
                S_PRX:   state <= S_EVX;
                S_EVX: begin
                    blk_x <= bus.obstacle;
                    state <= S_PRY;
                end
                S_PRY:   state <= S_EVY;
                S_EVY: begin
                    blk_y <= bus.obstacle;
                    state <= S_MOVE;
                end
                S_MOVE:  state <= S_DRAW;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic             en_xpos_c, en_ypos_c, en_xdir_c, en_ydir_c, en_timer_c, plot_c;
    logic [SEL_W-1:0] s_xpos_c, s_ypos_c, s_obs_xy_c;
    logic             s_xdir_c, s_ydir_c, s_timer_c, s_color_c;

    always_comb begin
        en_xpos_c  = 1'b0;
        en_ypos_c  = 1'b0;
        en_xdir_c  = 1'b0;
        en_ydir_c  = 1'b0;
        en_timer_c = 1'b0;
        plot_c     = 1'b0;
        s_xpos_c   = POS_LOAD;
        s_ypos_c   = POS_LOAD;
        s_obs_xy_c = PRB_UP;
        s_xdir_c   = DIR_SET;
        s_ydir_c   = DIR_SET;
        s_timer_c  = TMR_CLEAR;
        s_color_c  = 1'b0;
        case (state)
            S_INIT: begin
                en_xpos_c  = 1'b1;
                en_ypos_c  = 1'b1;
                en_xdir_c  = 1'b1;
                en_ydir_c  = 1'b1;
                en_timer_c = 1'b1;
            end
            S_DRAW: begin
                s_color_c  = 1'b1;
                plot_c     = 1'b1;
                en_timer_c = 1'b1;
            end
            S_WAIT: begin
                en_timer_c = ~bus.pause;
                s_timer_c  = TMR_INC;
            end
            S_ERASE: plot_c = 1'b1;
            S_PRX, S_EVX: begin
                s_obs_xy_c = bus.xdir ? PRB_RIGHT : PRB_LEFT;
                if (state == S_EVX && bus.obstacle) begin
                    en_xdir_c = 1'b1;
                    s_xdir_c  = DIR_TOGGLE;
                end
            end
            S_PRY, S_EVY: begin
                s_obs_xy_c = bus.ydir ? PRB_DOWN : PRB_UP;
                if (state == S_EVY && bus.obstacle) begin
                    en_ydir_c = 1'b1;
                    s_ydir_c  = DIR_TOGGLE;
                end
            end
            S_MOVE: begin
                en_xpos_c = ~blk_x;
                s_xpos_c  = step_sel(bus.xdir);
                en_ypos_c = ~blk_y;
                s_ypos_c  = step_sel(bus.ydir);
            end
            default: ;
        endcase
    end

    // Reset masks every strobe so an in-flight frame cannot touch the datapath.
    assign bus.en_xpos  = en_xpos_c  & ~reset;
    assign bus.en_ypos  = en_ypos_c  & ~reset;
    assign bus.en_xdir  = en_xdir_c  & ~reset;
    assign bus.en_ydir  = en_ydir_c  & ~reset;
    assign bus.en_timer = en_timer_c & ~reset;
    assign bus.plot     = plot_c     & ~reset;
    assign bus.s_xpos   = s_xpos_c;
    assign bus.s_ypos   = s_ypos_c;
    assign bus.s_xdir   = s_xdir_c;
    assign bus.s_ydir   = s_ydir_c;
    assign bus.s_timer  = s_timer_c;
    assign bus.s_color  = s_color_c;
    assign bus.s_obs_xy = s_obs_xy_c;
    assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Directed bench for obstacle_ctrl with a small behavioural datapath and obstacle RAM.
module tb_obstacle_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obstacle_ctrl_if bus();

    obstacle_ctrl #(.OBS_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Datapath model
    int   m_x = 0, m_y = 0, m_tmr = 0;
    logic m_xdir = 1'b0, m_ydir = 1'b0;
    logic obs_q = 1'b0;
    logic obs_force = 1'b0;
    int   limit = 2;
    int   wall_x = -1;
    int   p0x = -1, p0y = -1, p1x = -1, p1y = -1;

    function automatic logic hit(input int x, input int y);
        return (x == wall_x) || (x == p0x && y == p0y) || (x == p1x && y == p1y);
    endfunction

    always @(posedge clk) begin
        if (bus.en_xpos)
            case (bus.s_xpos)
                2'd0: m_x <= 80;
                2'd1: m_x <= m_x - 1;
                2'd2: m_x <= m_x + 1;
                default: m_x <= 0;
            endcase
        if (bus.en_ypos)
            case (bus.s_ypos)
                2'd0: m_y <= 60;
                2'd1: m_y <= m_y - 1;
                2'd2: m_y <= m_y + 1;
                default: m_y <= 0;
            endcase
        if (bus.en_xdir) m_xdir <= bus.s_xdir ? ~m_xdir : 1'b1;
        if (bus.en_ydir) m_ydir <= bus.s_ydir ? ~m_ydir : 1'b1;
        if (bus.en_timer) m_tmr <= bus.s_timer ? m_tmr + 1 : 0;
        case (bus.s_obs_xy)
            2'd0: obs_q <= hit(m_x, m_y - 1);
            2'd1: obs_q <= hit(m_x, m_y + 1);
            2'd2: obs_q <= hit(m_x - 1, m_y);
            default: obs_q <= hit(m_x + 1, m_y);
        endcase
    end

    assign bus.xdir       = m_xdir;
    assign bus.ydir       = m_ydir;
    assign bus.timer_done = (m_tmr == limit);
    assign bus.obstacle   = obs_q | obs_force;

    logic [16:0] obs_vec;
    assign obs_vec = {bus.busy, bus.plot, bus.s_color, bus.en_xpos, bus.s_xpos,
                      bus.en_ypos, bus.s_ypos, bus.en_xdir, bus.s_xdir,
                      bus.en_ydir, bus.s_ydir, bus.en_timer, bus.s_timer, bus.s_obs_xy};

    function automatic logic [16:0] pk(input logic b, p, c, ex, input logic [1:0] sx,
                                       input logic ey, input logic [1:0] sy,
                                       input logic exd, sxd, eyd, syd, et, st,
                                       input logic [1:0] so);
        return {b, p, c, ex, sx, ey, sy, exd, sxd, eyd, syd, et, st, so};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; obs_force = 1'b0;
        wall_x = -1; p0x = -1; p0y = -1; p1x = -1; p1y = -1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    // Advance until a DRAW (color=1) or ERASE (color=0) plot is seen, bounded.
    task automatic wait_plot(input logic color, input string name);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            tick;
            n++;
            found = (bus.plot === 1'b1 && bus.s_color === color);
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL %s: no plot with color %0b within %0d cycles", name, color, n);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.start = 1'b0; bus.pause = 1'b0;
        tick; tick;
        vectors++;
        if (obs_vec !== 17'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %h expected %h", obs_vec, 17'd0);
        end
        reset = 1'b0;
        tick;
        vectors++;
        if (obs_vec !== 17'd0) begin
            miscompares++; $display("FAIL idle_hold: got %h expected %h", obs_vec, 17'd0);
        end
    endtask

    task automatic test_start;
        logic [16:0] e [12];
        do_reset;
        e[0]  = pk(1,0,0, 1,2'd0, 1,2'd0, 1,0,1,0, 1,0, 2'd0);
        e[1]  = pk(1,1,1, 0,2'd0, 0,2'd0, 0,0,0,0, 1,0, 2'd0);
        e[2]  = pk(1,0,0, 0,2'd0, 0,2'd0, 0,0,0,0, 1,1, 2'd0);
        e[3]  = e[2];
        e[4]  = e[2];
        e[5]  = pk(1,1,0, 0,2'd0, 0,2'd0, 0,0,0,0, 0,0, 2'd0);
        e[6]  = pk(1,0,0, 0,2'd0, 0,2'd0, 0,0,0,0, 0,0, 2'd3);
        e[7]  = e[6];
        e[8]  = pk(1,0,0, 0,2'd0, 0,2'd0, 0,0,0,0, 0,0, 2'd1);
        e[9]  = e[8];
        e[10] = pk(1,0,0, 1,2'd2, 1,2'd2, 0,0,0,0, 0,0, 2'd0);
        e[11] = e[1];
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            bus.start = 1'b0;
            vectors++;
            if (obs_vec !== e[i]) begin
                miscompares++;
                $display("FAIL start_cycle%0d: got %h expected %h", i + 1, obs_vec, e[i]);
            end
        end
        chk_int("start_x", m_x, 81);
        chk_int("start_y", m_y, 61);
    endtask

    task automatic test_bounce;
        int expx [4];
        expx[0] = 81; expx[1] = 82; expx[2] = 82; expx[3] = 81;
        do_reset;
        wall_x = 83;
        pulse_start;
        wait_plot(1'b1, "bounce_first_draw");
        for (int f = 0; f < 4; f++) begin
            if (f == 2) begin
                wait_plot(1'b0, "bounce_erase_hit");
                tick;
                chk_int("bounce_prx_right", int'(bus.s_obs_xy), 3);
                tick;
                chk_int("bounce_evx_toggle", int'({bus.en_xdir, bus.s_xdir}), 3);
            end
            wait_plot(1'b1, "bounce_draw");
            chk_int("bounce_x", m_x, expx[f]);
            chk_int("bounce_y", m_y, 61 + f);
            if (f == 2) begin
                chk_int("bounce_xdir", int'(m_xdir), 0);
                wait_plot(1'b0, "bounce_erase_left");
                tick; chk_int("probe_prx_left", int'(bus.s_obs_xy), 2);
                tick; chk_int("probe_evx_left", int'(bus.s_obs_xy), 2);
                tick; chk_int("probe_pry_down", int'(bus.s_obs_xy), 1);
                tick; chk_int("probe_evy_down", int'(bus.s_obs_xy), 1);
            end
        end
    endtask

    task automatic test_corner;
        do_reset;
        p0x = 81; p0y = 60; p1x = 80; p1y = 61;
        pulse_start;
        wait_plot(1'b1, "corner_draw0");
        wait_plot(1'b1, "corner_draw1");
        chk_int("corner_x_hold", m_x, 80);
        chk_int("corner_y_hold", m_y, 60);
        chk_int("corner_xdir", int'(m_xdir), 0);
        chk_int("corner_ydir", int'(m_ydir), 0);
        wait_plot(1'b1, "corner_draw2");
        chk_int("corner_x_step", m_x, 79);
        chk_int("corner_y_step", m_y, 59);
    endtask

    task automatic test_pause;
        int n;
        do_reset;
        pulse_start;
        wait_plot(1'b1, "pause_draw");
        tick;
        tick;
        bus.pause = 1'b1;
        #1;
        chk_int("pause_en_timer", int'(bus.en_timer), 0);
        for (int k = 1; k < 5; k++) begin
            tick;
            chk_int("pause_en_timer", int'(bus.en_timer), 0);
        end
        tick;
        bus.pause = 1'b0;
        n = 7;
        while (!(bus.plot === 1'b1 && bus.s_color === 1'b0) && n < 60) begin
            tick;
            n++;
        end
        chk_int("pause_draw_to_erase", n, 9);
        wait_plot(1'b1, "pause_draw2");
        tick; tick; tick;
        bus.pause = 1'b1;
        #1;
        chk_int("pause_done_en_timer", int'({bus.en_timer, bus.timer_done}), 1);
        tick;
        chk_int("pause_done_erase", int'({bus.plot, bus.s_color}), 2);
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        pulse_start;
        wait_plot(1'b1, "rmid_draw0");
        wait_plot(1'b1, "rmid_draw1");
        chk_int("rmid_x_before", m_x, 81);
        wait_plot(1'b0, "rmid_erase");
        tick;
        tick;
        obs_force = 1'b1;
        reset = 1'b1;
        #1;
        chk_int("rmid_en_xdir", int'(bus.en_xdir), 0);
        tick;
        obs_force = 1'b0;
        vectors++;
        if (obs_vec !== 17'd0) begin
            miscompares++; $display("FAIL rmid_idle: got %h expected %h", obs_vec, 17'd0);
        end
        chk_int("rmid_xdir_kept", int'(m_xdir), 1);
        reset = 1'b0;
        tick;
        vectors++;
        if (obs_vec !== 17'd0) begin
            miscompares++; $display("FAIL rmid_stay_idle: got %h expected %h", obs_vec, 17'd0);
        end
        pulse_start;
        tick;
        chk_int("rmid_restart_draw", int'({bus.plot, bus.s_color}), 3);
        chk_int("rmid_x_init", m_x, 80);
        chk_int("rmid_y_init", m_y, 60);
        chk_int("rmid_dirs", int'({m_xdir, m_ydir}), 3);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        test_reset;
        test_start;
        test_bounce;
        test_corner;
        test_pause;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
